// File: rtl/writeback_unit_pkg.sv
// Shared widths and constants for the register-file write side.
package writeback_unit_pkg;
  localparam int ADDR_SIZE    = 5;
  localparam int WORD_SIZE    = 32;
  localparam int CNT_SIZE     = 2;
  localparam int MDU_MAX_WAIT = 4;
  localparam int REG_ZERO     = 0;
endpackage

// File: rtl/writeback_unit_if.sv
// Producer, regfile-write, issue and operand-lookup signals of the writeback unit.
interface writeback_unit_if
  import writeback_unit_pkg::ADDR_SIZE, writeback_unit_pkg::WORD_SIZE;
#(
  parameter int AW = ADDR_SIZE,
  parameter int DW = WORD_SIZE
) ();
  logic          pipe_valid;
  logic          pipe_ready;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_addr;
  logic [DW-1:0] mdu_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          rs_busy;
  logic          rt_busy;
  logic          rs_fwd_en;
  logic [DW-1:0] rs_fwd_data;
  logic          rt_fwd_en;
  logic [DW-1:0] rt_fwd_data;

  modport master (
    output pipe_valid, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
           issue_en, issue_addr, rs_addr, rt_addr,
    input  pipe_ready, mdu_ready, rd_en, rd_addr, rd_data,
           rs_busy, rt_busy, rs_fwd_en, rs_fwd_data, rt_fwd_en, rt_fwd_data
  );

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
           issue_en, issue_addr, rs_addr, rt_addr,
    output pipe_ready, mdu_ready, rd_en, rd_addr, rd_data,
           rs_busy, rt_busy, rs_fwd_en, rs_fwd_data, rt_fwd_en, rt_fwd_data
  );
endinterface

// File: rtl/writeback_unit_scoreboard.sv
// Per-register pending-write counters: +1 on issue, -1 on commit, busy when non-zero.
module writeback_unit_scoreboard
  import writeback_unit_pkg::REG_ZERO;
#(
  parameter int ADDR_SIZE = writeback_unit_pkg::ADDR_SIZE,
  parameter int CNT_SIZE  = writeback_unit_pkg::CNT_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_en,
  input  logic [ADDR_SIZE-1:0] issue_addr,
  input  logic                 commit_en,
  input  logic [ADDR_SIZE-1:0] commit_addr,
  input  logic [ADDR_SIZE-1:0] rs_addr,
  input  logic [ADDR_SIZE-1:0] rt_addr,
  output logic                 rs_busy,
  output logic                 rt_busy
);
  localparam int NREG = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] ZERO_ADDR = ADDR_SIZE'(REG_ZERO);

  logic [CNT_SIZE-1:0] count [NREG];
  logic [NREG-1:0]     inc_hit;
  logic [NREG-1:0]     dec_hit;
  logic                inc_any;
  logic                dec_any;

  assign inc_any = issue_en && issue_addr != ZERO_ADDR;
  assign dec_any = commit_en && commit_addr != ZERO_ADDR;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_hit[r] = inc_any && issue_addr == ADDR_SIZE'(r);
      dec_hit[r] = dec_any && commit_addr == ADDR_SIZE'(r);
    end
  end

  // Issue and commit of the same register in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) count[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_hit[r] && !dec_hit[r] && count[r] != '1)
          count[r] <= count[r] + 1'b1;
        else if (dec_hit[r] && !inc_hit[r] && count[r] != '0)
          count[r] <= count[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inc_any && !(dec_any && commit_addr == issue_addr) && count[issue_addr] == '1))
        else $error("scoreboard overflow on r%0d", issue_addr);
      assert (!(dec_any && !(inc_any && commit_addr == issue_addr) && count[commit_addr] == '0))
        else $error("scoreboard underflow on r%0d", commit_addr);
    end
  end

  assign rs_busy = count[rs_addr] != '0;
  assign rt_busy = count[rt_addr] != '0;
endmodule

// File: rtl/writeback_unit.sv
// Register-file write side: arbitrates pipeline vs MDU into one registered write port,
// forwards the in-flight write to decode and tracks pending writes per register.
module writeback_unit
  import writeback_unit_pkg::REG_ZERO;
#(
  parameter int ADDR_SIZE    = writeback_unit_pkg::ADDR_SIZE,
  parameter int WORD_SIZE    = writeback_unit_pkg::WORD_SIZE,
  parameter int CNT_SIZE     = writeback_unit_pkg::CNT_SIZE,
  parameter int MDU_MAX_WAIT = writeback_unit_pkg::MDU_MAX_WAIT
) (
  input logic             clk,
  input logic             rst,
  writeback_unit_if.slave bus
);
  localparam int WAIT_W = $clog2(MDU_MAX_WAIT + 1);
  localparam logic [ADDR_SIZE-1:0] ZERO_ADDR = ADDR_SIZE'(REG_ZERO);
  localparam logic [WAIT_W-1:0]    WAIT_MAX  = WAIT_W'(MDU_MAX_WAIT);

  logic                 pipe_acc;
  logic                 mdu_acc;
  logic                 take;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [WORD_SIZE-1:0] win_data;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [WAIT_W-1:0]    wait_nxt;
  logic                 starve;
  logic                 rd_en_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic [WORD_SIZE-1:0] rd_data_q;

  // Pipeline owns the port unless the MDU has been refused long enough to starve.
  assign bus.pipe_ready = !starve;
  assign bus.mdu_ready  = bus.mdu_valid && (starve || !bus.pipe_valid);
  assign pipe_acc       = bus.pipe_valid && !starve;
  assign mdu_acc        = bus.mdu_valid && (starve || !bus.pipe_valid);
  assign take           = pipe_acc || mdu_acc;
  assign win_addr       = mdu_acc ? bus.mdu_addr : bus.pipe_addr;
  assign win_data       = mdu_acc ? bus.mdu_data : bus.pipe_data;

  always_comb begin
    wait_nxt = wait_cnt;
    if (mdu_acc)
      wait_nxt = '0;
    else if (bus.mdu_valid && wait_cnt != WAIT_MAX)
      wait_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      starve    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      starve   <= !mdu_acc && wait_nxt == WAIT_MAX;
      // Writes to $zero are consumed but never reach the regfile.
      rd_en_q  <= take && win_addr != ZERO_ADDR;
      if (take) begin
        rd_addr_q <= win_addr;
        rd_data_q <= win_data;
      end
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_data = rd_data_q;

  assign bus.rs_fwd_en   = rd_en_q && rd_addr_q == bus.rs_addr && bus.rs_addr != ZERO_ADDR;
  assign bus.rs_fwd_data = bus.rs_fwd_en ? rd_data_q : '0;
  assign bus.rt_fwd_en   = rd_en_q && rd_addr_q == bus.rt_addr && bus.rt_addr != ZERO_ADDR;
  assign bus.rt_fwd_data = bus.rt_fwd_en ? rd_data_q : '0;

  writeback_unit_scoreboard #(
    .ADDR_SIZE (ADDR_SIZE),
    .CNT_SIZE  (CNT_SIZE)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (bus.issue_en),
    .issue_addr  (bus.issue_addr),
    .commit_en   (rd_en_q),
    .commit_addr (rd_addr_q),
    .rs_addr     (bus.rs_addr),
    .rt_addr     (bus.rt_addr),
    .rs_busy     (bus.rs_busy),
    .rt_busy     (bus.rt_busy)
  );
endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random stimulus; expected regfile writes are queued and a negedge monitor checks them.
module tb_writeback_unit;
  localparam int MAXW = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t expq[$];
  exp_t mon_e;
  int   m_wait = 0;
  bit   m_starve = 1'b0;
  bit   last_pacc, last_macc;

  writeback_unit_if bus ();
  writeback_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every committed write must match the oldest expectation, in its expected cycle.
  always @(negedge clk) begin
    if (bus.rd_en === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got r%0d=%h expected no write (cycle %0d)", bus.rd_addr, bus.rd_data, cyc);
      end else begin
        mon_e = expq.pop_front();
        if (bus.rd_addr !== mon_e.a || bus.rd_data !== mon_e.d || cyc != mon_e.c) begin
          bad++;
          $display("FAIL write: got r%0d=%h @%0d expected r%0d=%h @%0d",
                   bus.rd_addr, bus.rd_data, cyc, mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end
    if (expq.size() > 0 && expq[0].c < cyc) begin
      mon_e = expq.pop_front();
      total++;
      bad++;
      $display("FAIL lost_write: got none expected r%0d=%h @%0d", mon_e.a, mon_e.d, mon_e.c);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, then at negedge check ready against the arbitration model and queue writes.
  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic ie, input logic [4:0] ia);
    logic exp_pr, exp_mr;
    bus.pipe_valid = pv; bus.pipe_addr = pa; bus.pipe_data = pd;
    bus.mdu_valid  = mv; bus.mdu_addr  = ma; bus.mdu_data  = md;
    bus.issue_en   = ie; bus.issue_addr = ia;
    @(negedge clk);
    exp_pr = !m_starve;
    exp_mr = mv && (m_starve || !pv);
    check("pipe_ready", {31'd0, bus.pipe_ready}, {31'd0, exp_pr});
    check("mdu_ready", {31'd0, bus.mdu_ready}, {31'd0, exp_mr});
    last_pacc = pv && exp_pr;
    last_macc = mv && exp_mr;
    if (last_pacc && pa != 5'd0) expq.push_back('{pa, pd, cyc + 1});
    if (last_macc && ma != 5'd0) expq.push_back('{ma, md, cyc + 1});
    if (last_macc) begin
      m_wait = 0;
      m_starve = 1'b0;
    end else if (mv) begin
      if (m_wait < MAXW) m_wait++;
      if (m_wait == MAXW) m_starve = 1'b1;
    end
  endtask

  task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic ie, input logic [4:0] ia);
    drive(pv, pa, pd, mv, ma, md, ie, ia);
    tick();
  endtask

  task automatic idle_check_busy(input logic rs_exp, input logic rt_exp, input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check({tag, "_rs_busy"}, {31'd0, bus.rs_busy}, {31'd0, rs_exp});
    check({tag, "_rt_busy"}, {31'd0, bus.rt_busy}, {31'd0, rt_exp});
    tick();
  endtask

  logic       p_has, m_has;
  logic [4:0] pa_r, ma_r, ia_r;
  logic [31:0] pd_r, md_r;
  logic       ie_r;

  initial begin
    bus.pipe_valid = 0; bus.pipe_addr = 0; bus.pipe_data = 0;
    bus.mdu_valid = 0; bus.mdu_addr = 0; bus.mdu_data = 0;
    bus.issue_en = 0; bus.issue_addr = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    bus.rs_addr = 5; bus.rt_addr = 7;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check("rst_rd_addr", {27'd0, bus.rd_addr}, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_rs_busy", {31'd0, bus.rs_busy}, 32'd0);
    tick();

    // Pipeline write, forwarding in the following cycle only
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5);
    bus.rs_addr = 5; bus.rt_addr = 6;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("fwd_rs_en", {31'd0, bus.rs_fwd_en}, 32'd1);
    check("fwd_rs_data", bus.rs_fwd_data, 32'hDEADBEEF);
    check("fwd_rt_en", {31'd0, bus.rt_fwd_en}, 32'd0);
    check("fwd_rt_data", bus.rt_fwd_data, 32'd0);
    check("fwd_rs_busy", {31'd0, bus.rs_busy}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("fwd_done_en", {31'd0, bus.rs_fwd_en}, 32'd0);
    check("fwd_done_busy", {31'd0, bus.rs_busy}, 32'd0);
    tick();

    // Write to $zero is consumed without a regfile write
    bus.rs_addr = 0;
    step(1, 0, 32'h1234, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("zero_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check("zero_fwd_en", {31'd0, bus.rs_fwd_en}, 32'd0);
    tick();

    // MDU starvation: refused four cycles, wins the fifth
    step(0, 0, 0, 0, 0, 0, 1, 9);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 0, 0, 1, 5'(i));
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'(i + 1), 32'h100 + 32'(i), 1, 9, 32'h42, 0, 0);
      check("starve_mdu_ready", {31'd0, bus.mdu_ready}, {31'd0, i == 4});
      check("starve_pipe_ready", {31'd0, bus.pipe_ready}, {31'd0, i != 4});
      tick();
    end
    drive(1, 0, 32'h5, 1, 0, 32'h6, 0, 0);
    check("resume_mdu_ready", {31'd0, bus.mdu_ready}, 32'd0);
    tick();
    step(0, 0, 0, 1, 0, 32'h6, 0, 0);

    // Scoreboard counting on r7
    bus.rs_addr = 7; bus.rt_addr = 7;
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    check("sb_issue_invisible", {31'd0, bus.rs_busy}, 32'd0);
    tick();
    step(0, 0, 0, 0, 0, 0, 1, 7);
    step(1, 7, 32'h77, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle_check_busy(1, 1, "sb_one_left");
    step(1, 7, 32'h78, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle_check_busy(0, 0, "sb_drained");
    step(0, 0, 0, 0, 0, 0, 1, 7);
    step(1, 7, 32'h79, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7);
    idle_check_busy(1, 1, "sb_same_cycle");
    step(1, 7, 32'h7A, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle_check_busy(0, 0, "sb_final");

    // Reset mid-stream drops the in-flight write and clears the scoreboard
    step(0, 0, 0, 0, 0, 0, 1, 12);
    step(0, 0, 0, 0, 0, 0, 1, 12);
    bus.rs_addr = 12; bus.rt_addr = 12;
    step(1, 12, 32'hC0FFEE, 0, 0, 0, 0, 0);
    rst = 1'b1;
    bus.pipe_valid = 1; bus.pipe_addr = 13; bus.pipe_data = 32'hBAD;
    repeat (2) tick();
    rst = 1'b0; m_wait = 0; m_starve = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("midrst_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check("midrst_rs_busy", {31'd0, bus.rs_busy}, 32'd0);
    check("midrst_rt_busy", {31'd0, bus.rt_busy}, 32'd0);
    tick();

    // Random producer streams; each result is issued when first presented
    p_has = 0; m_has = 0; pa_r = 0; pd_r = 0; ma_r = 0; md_r = 0;
    for (int k = 0; k < 300; k++) begin
      ie_r = 0; ia_r = 0;
      if (!m_has && $urandom_range(0, 3) == 0) begin
        m_has = 1; ma_r = 5'($urandom_range(0, 31)); md_r = $urandom;
        ie_r = (ma_r != 0); ia_r = ma_r;
      end else if (!p_has && $urandom_range(0, 1) == 0) begin
        p_has = 1; pa_r = 5'($urandom_range(0, 31)); pd_r = $urandom;
        ie_r = (pa_r != 0); ia_r = pa_r;
      end
      drive(p_has, pa_r, pd_r, m_has, ma_r, md_r, ie_r, ia_r);
      if (last_pacc) p_has = 0;
      if (last_macc) m_has = 0;
      tick();
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    check("queue_drained", 32'(expq.size()), 32'd0);
    for (int r = 1; r < 32; r++) begin
      bus.rs_addr = 5'(r);
      bus.rt_addr = 5'(32 - r);
      #1;
      check("final_rs_busy", {31'd0, bus.rs_busy}, 32'd0);
      check("final_rt_busy", {31'd0, bus.rt_busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
